iclock_ctrl: RTL and testbench

Mode and alarm controller for the iClock design. Sequences the time-of-day counters (hour/min/sec), the alarm setpoint and the alarm-enable flag from debounced key pulses and a 1 Hz tick. Drives binary time fields and a field-select/blink mask to the seven-segment display formatter, and a buzzer-enable level to the tone generator. Sits between the key debouncer/prescaler and the display/buzzer drivers inside the iClock top level.

---
 rtl/iclock_pkg.sv | 46 ++++
 rtl/iclock_ctrl_if.sv | 34 +++
 rtl/mod_counter.sv | 45 ++++
 rtl/iclock_ctrl.sv | 127 ++++++++++++
 tb/tb_iclock_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/iclock_pkg.sv
// ---------------------------------------------------------------
// iclock_pkg : mode encodings, key indices and field limits
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package iclock_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_AHOUR = 3'd3,
    SET_AMIN  = 3'd4
  } mode_e;

  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_DEC  = 2;
  localparam int KEY_ALM  = 3;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      RUN:       return SET_HOUR;
      SET_HOUR:  return SET_MIN;
      SET_MIN:   return SET_AHOUR;
      SET_AHOUR: return SET_AMIN;
      default:   return RUN;
    endcase
  endfunction

  // [1] hour field blinks, [0] minute field blinks
  function automatic logic [1:0] blink_of(input mode_e m);
    case (m)
      SET_HOUR, SET_AHOUR: return 2'b10;
      SET_MIN,  SET_AMIN:  return 2'b01;
      default:             return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/iclock_ctrl_if.sv
// ---------------------------------------------------------------
// iclock_ctrl_if : key/tick inputs and time/alarm/display outputs
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface iclock_ctrl_if;
  import iclock_pkg::*;

  logic [3:0] key_pulse;
  logic       tick_1hz;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  mode_e      mode;
  logic [1:0] blink_mask;
  logic       buzz_en;

  modport master (
    output key_pulse, tick_1hz,
    input  hour, min, sec, alarm_hour, alarm_min, alarm_en, mode, blink_mask, buzz_en
  );

  modport slave (
    input  key_pulse, tick_1hz,
    output hour, min, sec, alarm_hour, alarm_min, alarm_en, mode, blink_mask, buzz_en
  );

endinterface

`default_nettype wire

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------
// mod_counter : modulo-(MAX+1) up/down counter with clear and wrap carry
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mod_counter #(
  parameter int MAX     = 59,
  parameter int W       = 6,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] val_o,
  output logic         carry_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] RST_V = W'(RST_VAL);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i)      val_d = '0;
    else if (inc_i) val_d = (val_q == MAX_V) ? '0 : val_q + 1'b1;
    else if (dec_i) val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= RST_V;
    else        val_q <= val_d;
  end

  assign val_o = val_q;
  // Carry ignores clr so a simultaneous clear still propagates the wrap
  assign carry_o = inc_i && (val_q == MAX_V);

endmodule

`default_nettype wire

// File: rtl/iclock_ctrl.sv
// ---------------------------------------------------------------
// iclock_ctrl : iClock mode sequencer, time/alarm counters and buzzer control
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module iclock_ctrl #(
  parameter int ALARM_SECS = 60,
  parameter int RST_AHOUR  = 7,
  parameter int RST_AMIN   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  iclock_ctrl_if.slave bus
);
  import iclock_pkg::*;

  mode_e      mode_q;
  logic [1:0] blink_q;
  logic       alarm_en_q;
  logic       buzz_en_q;
  logic [7:0] ring_q;

  logic [5:0] sec_w, min_w, amin_w;
  logic [4:0] hour_w, ahour_w;
  logic       sec_carry_w, min_carry_w;
  logic [5:0] next_min_w;
  logic [4:0] next_hour_w;

  wire [3:0] key_w  = bus.key_pulse;
  wire       tick_w = bus.tick_1hz;

  wire count_w    = (mode_q == RUN) || (mode_q == SET_AHOUR) || (mode_q == SET_AMIN);
  wire tick_cnt_w = tick_w && count_w;

  wire min_wrap_w = (min_w == 6'(MIN_MAX));
  assign next_min_w  = min_wrap_w ? 6'd0 : min_w + 6'd1;
  assign next_hour_w = !min_wrap_w ? hour_w :
                       (hour_w == 5'(HOUR_MAX)) ? 5'd0 : hour_w + 5'd1;

  wire trigger_w = tick_w && (mode_q == RUN) && alarm_en_q && !buzz_en_q &&
                   (sec_w == 6'(MIN_MAX)) &&
                   (next_hour_w == ahour_w) && (next_min_w == amin_w);

  // Keys are swallowed while ringing (silencer) and on the trigger cycle
  wire keys_live_w = !buzz_en_q && !trigger_w;
  wire mode_key_w  = keys_live_w && key_w[KEY_MODE];
  wire inc_key_w   = keys_live_w && !key_w[KEY_MODE] && key_w[KEY_INC];
  wire dec_key_w   = keys_live_w && !key_w[KEY_MODE] && !key_w[KEY_INC] && key_w[KEY_DEC];
  wire alm_key_w   = keys_live_w && (key_w[2:0] == 3'b000) && key_w[KEY_ALM];

  mod_counter #(.MAX(MIN_MAX), .W(6), .RST_VAL(0)) u_sec (
    .clk(clk), .rst_n(rst_n),
    .clr_i(mode_key_w && (mode_q == RUN)), .inc_i(tick_cnt_w), .dec_i(1'b0),
    .val_o(sec_w), .carry_o(sec_carry_w)
  );

  mod_counter #(.MAX(MIN_MAX), .W(6), .RST_VAL(0)) u_min (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .inc_i(sec_carry_w || (inc_key_w && (mode_q == SET_MIN))),
    .dec_i(dec_key_w && (mode_q == SET_MIN)),
    .val_o(min_w), .carry_o(min_carry_w)
  );

  // Manual minute adjust must not ripple into the hour, hence count_w gating
  mod_counter #(.MAX(HOUR_MAX), .W(5), .RST_VAL(0)) u_hour (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .inc_i((min_carry_w && count_w) || (inc_key_w && (mode_q == SET_HOUR))),
    .dec_i(dec_key_w && (mode_q == SET_HOUR)),
    .val_o(hour_w), .carry_o()
  );

  mod_counter #(.MAX(MIN_MAX), .W(6), .RST_VAL(RST_AMIN)) u_amin (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .inc_i(inc_key_w && (mode_q == SET_AMIN)),
    .dec_i(dec_key_w && (mode_q == SET_AMIN)),
    .val_o(amin_w), .carry_o()
  );

  mod_counter #(.MAX(HOUR_MAX), .W(5), .RST_VAL(RST_AHOUR)) u_ahour (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .inc_i(inc_key_w && (mode_q == SET_AHOUR)),
    .dec_i(dec_key_w && (mode_q == SET_AHOUR)),
    .val_o(ahour_w), .carry_o()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= RUN;
      blink_q    <= 2'b00;
      alarm_en_q <= 1'b0;
      buzz_en_q  <= 1'b0;
      ring_q     <= 8'd0;
    end else begin
      if (mode_key_w) begin
        mode_q  <= next_mode(mode_q);
        blink_q <= blink_of(next_mode(mode_q));
      end
      if (alm_key_w && (mode_q == RUN))
        alarm_en_q <= !alarm_en_q;
      if (trigger_w) begin
        buzz_en_q <= 1'b1;
        ring_q    <= 8'd0;
      end else if (buzz_en_q) begin
        if (|key_w)
          buzz_en_q <= 1'b0;
        else if (tick_w) begin
          if (ring_q == 8'(ALARM_SECS - 1)) buzz_en_q <= 1'b0;
          else                              ring_q    <= ring_q + 8'd1;
        end
      end
    end
  end

  assign bus.hour       = hour_w;
  assign bus.min        = min_w;
  assign bus.sec        = sec_w;
  assign bus.alarm_hour = ahour_w;
  assign bus.alarm_min  = amin_w;
  assign bus.alarm_en   = alarm_en_q;
  assign bus.mode       = mode_q;
  assign bus.blink_mask = blink_q;
  assign bus.buzz_en    = buzz_en_q;

endmodule

`default_nettype wire

// File: tb/tb_iclock_ctrl.sv
// ---------------------------------------------------------------
// tb_iclock_ctrl : directed self-checking bench for iclock_ctrl
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_iclock_ctrl;

  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_INC  = 4'b0010;
  localparam logic [3:0] K_DEC  = 4'b0100;
  localparam logic [3:0] K_ALM  = 4'b1000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  iclock_ctrl_if bus();

  iclock_ctrl #(.ALARM_SECS(60), .RST_AHOUR(7), .RST_AMIN(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k, input logic t);
    @(negedge clk);
    bus.key_pulse = k;
    bus.tick_1hz  = t;
    @(negedge clk);
    bus.key_pulse = '0;
    bus.tick_1hz  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) press(4'b0000, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, 32'(bus.hour), 32'(h));
    chk({tag, ".min"},  32'(bus.min),  32'(m));
    chk({tag, ".sec"},  32'(bus.sec),  32'(s));
  endtask

  // Time 06:59:59 in RUN, alarm still 07:00 and disarmed
  task automatic setup_0659();
    do_reset();
    press(K_MODE, 1'b0);
    repeat (6) press(K_INC, 1'b0);
    press(K_MODE, 1'b0);
    press(K_DEC, 1'b0);
    repeat (3) press(K_MODE, 1'b0);
    ticks(59);
    chk_time("setup", 6, 59, 59);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    bus.key_pulse = '0;
    bus.tick_1hz  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk_time("rst", 0, 0, 0);
    chk("rst.ahour", 32'(bus.alarm_hour), 7);
    chk("rst.amin",  32'(bus.alarm_min),  0);
    chk("rst.aen",   32'(bus.alarm_en),   0);
    chk("rst.mode",  32'(bus.mode),       0);
    chk("rst.blink", 32'(bus.blink_mask), 0);
    chk("rst.buzz",  32'(bus.buzz_en),    0);

    // One hour, one minute, one second of ticks
    ticks(3661);
    chk_time("run3661", 1, 1, 1);

    // Hour adjust with frozen time
    do_reset();
    press(K_MODE, 1'b0);
    chk("sh.mode",  32'(bus.mode),       1);
    chk("sh.blink", 32'(bus.blink_mask), 2);
    repeat (3) press(K_DEC, 1'b0);
    ticks(5);
    chk_time("sh", 21, 0, 0);
    press(K_ALM, 1'b0);
    chk("sh.alm_ignored", 32'(bus.alarm_en), 0);
    press(K_MODE, 1'b0);
    chk("sm.mode",  32'(bus.mode),       2);
    chk("sm.blink", 32'(bus.blink_mask), 1);
    ticks(2);
    chk("sm.sec", 32'(bus.sec), 0);
    press(K_MODE, 1'b0);
    chk("sah.mode",  32'(bus.mode),       3);
    chk("sah.blink", 32'(bus.blink_mask), 2);
    ticks(1);
    chk_time("sah", 21, 0, 1);

    // Alarm minute wrap and key priority
    press(K_MODE, 1'b0);
    chk("sam.mode",  32'(bus.mode),       4);
    chk("sam.blink", 32'(bus.blink_mask), 1);
    press(K_DEC, 1'b0);
    chk("sam.dec_wrap", 32'(bus.alarm_min), 59);
    press(K_INC, 1'b0);
    chk("sam.inc_wrap", 32'(bus.alarm_min), 0);
    press(K_INC | K_DEC, 1'b0);
    chk("sam.inc_over_dec", 32'(bus.alarm_min), 1);
    press(K_INC, 1'b1);
    chk("sam.inc_tick.amin", 32'(bus.alarm_min), 2);
    chk("sam.inc_tick.sec",  32'(bus.sec),       2);
    chk("sam.ahour",         32'(bus.alarm_hour), 7);
    press(K_MODE, 1'b0);
    chk("run.mode",  32'(bus.mode),       0);
    chk("run.blink", 32'(bus.blink_mask), 0);
    press(K_MODE | K_INC, 1'b0);
    chk("prio.mode", 32'(bus.mode), 1);
    chk_time("prio", 21, 0, 0);

    // MODE with tick at sec 59: clear wins, carry still taken
    do_reset();
    ticks(59);
    press(K_MODE, 1'b1);
    chk_time("modetick", 0, 1, 0);
    chk("modetick.mode", 32'(bus.mode), 1);

    // Day wrap 23:59:59 -> 00:00:00
    do_reset();
    press(K_MODE, 1'b0);
    press(K_DEC, 1'b0);
    press(K_MODE, 1'b0);
    press(K_DEC, 1'b0);
    chk_time("wrapset", 23, 59, 0);
    repeat (3) press(K_MODE, 1'b0);
    ticks(59);
    chk_time("pre_wrap", 23, 59, 59);
    ticks(1);
    chk_time("day_wrap", 0, 0, 0);

    // Alarm rings for exactly 60 ticks
    setup_0659();
    press(K_ALM, 1'b0);
    chk("arm.aen", 32'(bus.alarm_en), 1);
    ticks(1);
    chk("ring.buzz", 32'(bus.buzz_en), 1);
    chk_time("ring", 7, 0, 0);
    ticks(59);
    chk("ring59.buzz", 32'(bus.buzz_en), 1);
    ticks(1);
    chk("ring60.buzz", 32'(bus.buzz_en), 0);
    chk("ring60.aen",  32'(bus.alarm_en), 1);

    // Key silences the ring and is consumed
    setup_0659();
    press(K_ALM, 1'b0);
    ticks(1);
    chk("sil.pre_buzz", 32'(bus.buzz_en), 1);
    press(K_INC, 1'b0);
    chk("sil.buzz", 32'(bus.buzz_en),  0);
    chk("sil.mode", 32'(bus.mode),     0);
    chk("sil.aen",  32'(bus.alarm_en), 1);
    chk_time("sil", 7, 0, 0);

    // Asynchronous reset mid-ring, sampled before any clock edge
    setup_0659();
    press(K_ALM, 1'b0);
    ticks(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ring.buzz",  32'(bus.buzz_en),    0);
    chk("arst_ring.mode",  32'(bus.mode),       0);
    chk("arst_ring.aen",   32'(bus.alarm_en),   0);
    chk("arst_ring.ahour", 32'(bus.alarm_hour), 7);
    chk("arst_ring.amin",  32'(bus.alarm_min),  0);
    chk_time("arst_ring", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-set in SET_AHOUR
    repeat (3) press(K_MODE, 1'b0);
    press(K_INC, 1'b0);
    ticks(3);
    chk("sah2.ahour", 32'(bus.alarm_hour), 8);
    chk("sah2.sec",   32'(bus.sec),        3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_set.ahour", 32'(bus.alarm_hour), 7);
    chk("arst_set.mode",  32'(bus.mode),       0);
    chk("arst_set.blink", 32'(bus.blink_mask), 0);
    chk_time("arst_set", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
